// File: rtl/spi_target.sv
// spi_target: SPI mode-0 responder.
//   Oversamples cs_n/sck/mosi/dc on clk. Received bytes go to a host-visible
//   holding register together with their D/C bit. Host-loaded bytes are shifted
//   out on spi_miso, MSB first.
// Optional build macro: SPI_TARGET_RX_FIFO_EN (4-entry receive FIFO instead of
//   the single receive holding register).
// Ports:
//   clk, rst             system clock, asynchronous active-high reset
//   spi_cs_n, spi_sck,
//   spi_mosi, spi_dc     SPI pins from the controller (asynchronous)
//   spi_miso, spi_miso_oe  data to the controller and its pad enable
//   rx_data, rx_dc, rx_valid, rx_read   host receive interface
//   tx_data, tx_load, tx_full           host transmit interface
//   rx_overrun, tx_underrun, status_clear  sticky error flags and their clear
module spi_target #(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_MISO   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_cs_n,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  input  logic       spi_dc,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic [7:0] rx_data,
  output logic       rx_dc,
  output logic       rx_valid,
  input  logic       rx_read,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_full,
  output logic       rx_overrun,
  output logic       tx_underrun,
  input  logic       status_clear
);

  logic [SYNC_STAGES-1:0] cs_sync, sck_sync, mosi_sync, dc_sync;
  logic cs_d, sck_d;
  logic cs_s, sck_s, mosi_s, dc_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync   <= '1;
      sck_sync  <= '0;
      mosi_sync <= '0;
      dc_sync   <= '0;
      cs_d      <= 1'b1;
      sck_d     <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0], spi_dc};
      cs_d      <= cs_s;
      sck_d     <= sck_s;
    end
  end

  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign dc_s   = dc_sync[SYNC_STAGES-1];

  logic       cs_fall, sck_rise, sck_fall, byte_done, tx_evt, rx_ovr_set;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;   // only the 7 earlier bits of a byte need storing
  logic [7:0] rx_byte;
  logic [7:0] tx_shift, tx_hold;

  assign cs_fall   = cs_d & ~cs_s;
  assign sck_rise  = ~cs_s & ~sck_d & sck_s;
  assign sck_fall  = ~cs_s & sck_d & ~sck_s;
  assign byte_done = sck_rise & (bit_cnt == 3'd7);
  assign rx_byte   = {rx_shift, mosi_s};
  // The fall after the 8th rise finds bit_cnt already wrapped to 0.
  assign tx_evt    = cs_fall | (sck_fall & (bit_cnt == 3'd0));

  assign spi_miso_oe = ~cs_s;
  assign spi_miso    = cs_s ? IDLE_MISO : tx_shift[7];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt     <= '0;
      rx_shift    <= '1;
      tx_shift    <= '1;
      tx_hold     <= '0;
      tx_full     <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      if (cs_s) begin
        bit_cnt  <= '0;
        rx_shift <= '1;
      end else if (sck_rise) begin
        rx_shift <= rx_byte[6:0];
        bit_cnt  <= bit_cnt + 3'd1;
      end

      if (tx_evt) begin
        tx_shift <= tx_full ? tx_hold : 8'hFF;
      end else if (sck_fall) begin
        tx_shift <= {tx_shift[6:0], 1'b1};
      end

      // A load arriving with a shifter load event lands after the transfer.
      if (tx_evt) begin
        tx_full <= tx_load;
        if (tx_load) tx_hold <= tx_data;
      end else if (tx_load && !tx_full) begin
        tx_full <= 1'b1;
        tx_hold <= tx_data;
      end

      // Set events are written last so they win over a same-cycle clear.
      if (status_clear) begin
        rx_overrun  <= 1'b0;
        tx_underrun <= 1'b0;
      end
      if (rx_ovr_set)          rx_overrun  <= 1'b1;
      if (tx_evt && !tx_full)  tx_underrun <= 1'b1;
    end
  end

`ifdef SPI_TARGET_RX_FIFO_EN
  logic [8:0] fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] fifo_cnt;
  logic       fifo_full, push, pop;

  assign fifo_full  = (fifo_cnt == 3'd4);
  assign pop        = rx_read & (fifo_cnt != 3'd0);
  assign push       = byte_done & (~fifo_full | rx_read);
  assign rx_ovr_set = byte_done & fifo_full & ~rx_read;
  assign rx_valid   = (fifo_cnt != 3'd0);
  assign rx_data    = fifo_mem[rd_ptr][7:0];
  assign rx_dc      = fifo_mem[rd_ptr][8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {dc_s, rx_byte};
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end
`else
  assign rx_ovr_set = byte_done & rx_valid & ~rx_read;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data  <= '0;
      rx_dc    <= 1'b0;
      rx_valid <= 1'b0;
    end else if (byte_done) begin
      rx_data  <= rx_byte;
      rx_dc    <= dc_s;
      rx_valid <= 1'b1;
    end else if (rx_read) begin
      rx_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_spi_target.sv
module tb_spi_target;
  localparam int   SYNC = 2;
  localparam logic IDLE = 1'b1;
  localparam int   H    = 6;
`ifdef SPI_TARGET_RX_FIFO_EN
  localparam int   RX_DEPTH = 4;
`else
  localparam int   RX_DEPTH = 1;
`endif

  logic       clk, rst;
  logic       spi_cs_n, spi_sck, spi_mosi, spi_dc;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] rx_data;
  logic       rx_dc, rx_valid, rx_read;
  logic [7:0] tx_data;
  logic       tx_load, tx_full, rx_overrun, tx_underrun, status_clear;

  spi_target #(.SYNC_STAGES(SYNC), .IDLE_MISO(IDLE)) dut (
    .clk(clk), .rst(rst),
    .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_dc(spi_dc),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .rx_data(rx_data), .rx_dc(rx_dc), .rx_valid(rx_valid), .rx_read(rx_read),
    .tx_data(tx_data), .tx_load(tx_load), .tx_full(tx_full),
    .rx_overrun(rx_overrun), .tx_underrun(tx_underrun), .status_clear(status_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  bit settled = 0;

  // Transaction-level model: receive queue, TX holding slot, byte on the wire.
  logic [8:0] m_rxq [$];
  bit         m_ovr, m_und, m_hold_full;
  logic [7:0] m_hold, m_cur;
  logic [8:0] cmp_head;
  logic [7:0] mb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_rxq.delete();
    m_ovr = 0; m_und = 0; m_hold_full = 0; m_hold = 8'h00; m_cur = 8'hFF;
  endtask

  task automatic model_tx_evt();
    if (m_hold_full) begin
      m_cur = m_hold;
      m_hold_full = 0;
    end else begin
      m_cur = 8'hFF;
      m_und = 1;
    end
  endtask

  task automatic model_rx(input logic [7:0] d, input logic dc);
    if (m_rxq.size() < RX_DEPTH) m_rxq.push_back({dc, d});
    else begin
      m_ovr = 1;
      if (RX_DEPTH == 1) m_rxq[0] = {dc, d};
    end
  endtask

  task automatic model_load(input logic [7:0] v);
    if (!m_hold_full) begin
      m_hold = v;
      m_hold_full = 1;
    end
  endtask

  task automatic host_load(input logic [7:0] v);
    settled = 0;
    tx_data = v; tx_load = 1'b1;
    cyc(1);
    tx_load = 1'b0;
    model_load(v);
    cyc(2);
    settled = 1;
  endtask

  task automatic host_read();
    settled = 0;
    rx_read = 1'b1;
    cyc(1);
    rx_read = 1'b0;
    if (m_rxq.size() != 0) void'(m_rxq.pop_front());
    cyc(2);
    settled = 1;
  endtask

  task automatic host_clear();
    settled = 0;
    status_clear = 1'b1;
    cyc(1);
    status_clear = 1'b0;
    m_ovr = 0; m_und = 0;
    cyc(2);
    settled = 1;
  endtask

  task automatic spi_select();
    settled = 0;
    spi_cs_n = 1'b0;
    model_tx_evt();
    cyc(H);
  endtask

  task automatic spi_deselect();
    spi_cs_n = 1'b1;
    cyc(SYNC + 3);
    settled = 1;
  endtask

  // Clocks nbits bits of d; a host load of load_val follows the fall of bit load_at.
  task automatic spi_byte(input logic [7:0] d, input logic dc, input int nbits,
                          input int load_at, input logic [7:0] load_val,
                          output logic [7:0] miso_byte);
    miso_byte = 8'hFF;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = d[7-i];
      spi_dc   = dc;
      cyc(H);
      miso_byte[7-i] = spi_miso;
      check("miso_bit", spi_miso, m_cur[7-i]);
      spi_sck = 1'b1;
      cyc(H);
      spi_sck = 1'b0;
      if (i == load_at) begin
        tx_data = load_val; tx_load = 1'b1;
        cyc(1);
        tx_load = 1'b0;
        model_load(load_val);
      end
    end
    cyc(H);
    if (nbits == 8) begin
      model_rx(d, dc);
      model_tx_evt();
    end
  endtask

  always @(negedge clk) begin
    if (settled && !rst) begin
      check("rx_valid", rx_valid, m_rxq.size() != 0);
      if (m_rxq.size() != 0) begin
        cmp_head = m_rxq[0];
        check("rx_data", rx_data, cmp_head[7:0]);
        check("rx_dc", rx_dc, cmp_head[8]);
      end
      check("tx_full", tx_full, m_hold_full);
      check("rx_overrun", rx_overrun, m_ovr);
      check("tx_underrun", tx_underrun, m_und);
      check("miso_oe_idle", spi_miso_oe, 1'b0);
      check("miso_idle", spi_miso, IDLE);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check_reset_outputs();
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_dc", rx_dc, 1'b0);
    check("rst_tx_full", tx_full, 1'b0);
    check("rst_rx_overrun", rx_overrun, 1'b0);
    check("rst_tx_underrun", tx_underrun, 1'b0);
    check("rst_miso_oe", spi_miso_oe, 1'b0);
    check("rst_miso", spi_miso, IDLE);
  endtask

  initial begin
    int nb, la;
    rst = 1'b1; spi_cs_n = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0; spi_dc = 1'b0;
    rx_read = 1'b0; tx_data = 8'h00; tx_load = 1'b0; status_clear = 1'b0;
    model_reset();
    cyc(3);
    check_reset_outputs();
    rst = 1'b0;
    cyc(SYNC + 3);
    settled = 1;

    // Reset mid-transfer, then a clean byte.
    spi_select();
    spi_byte(8'hFF, 1'b0, 3, -1, 8'h00, mb);
    rst = 1'b1; spi_cs_n = 1'b1; spi_sck = 1'b0;
    cyc(1);
    check_reset_outputs();
    model_reset();
    cyc(2);
    rst = 1'b0;
    cyc(SYNC + 3);
    settled = 1;
    spi_select();
    spi_byte(8'hA5, 1'b1, 8, -1, 8'h00, mb);
    spi_deselect();
    check("a5_data", rx_data, 8'hA5);
    check("a5_dc", rx_dc, 1'b1);
    host_read();
    host_clear();

    // Preloaded TX byte while receiving 0xC3.
    host_load(8'h3C);
    spi_select();
    check("tx_full_after_sel", tx_full, 1'b0);
    spi_byte(8'hC3, 1'b0, 8, -1, 8'h00, mb);
    spi_deselect();
    check("miso_3c", mb, 8'h3C);
    check("c3_data", rx_data, 8'hC3);
    host_read();

    // Back-to-back bytes without a read.
    spi_select();
    spi_byte(8'h11, 1'b0, 8, -1, 8'h00, mb);
    spi_byte(8'h22, 1'b1, 8, -1, 8'h00, mb);
    spi_deselect();
`ifdef SPI_TARGET_RX_FIFO_EN
    check("b2b_head", rx_data, 8'h11);
    host_read();
`endif
    check("b2b_data", rx_data, 8'h22);
`ifndef SPI_TARGET_RX_FIFO_EN
    check("b2b_overrun", rx_overrun, 1'b1);
`endif
    host_clear();
    check("ovr_cleared", rx_overrun, 1'b0);
    host_read();

    // Underrun, then a load during byte 1 feeds byte 2.
    spi_select();
    spi_byte(8'h00, 1'b0, 8, 3, 8'h5A, mb);
    check("underrun_ff", mb, 8'hFF);
    spi_byte(8'h00, 1'b0, 8, -1, 8'h00, mb);
    check("byte2_5a", mb, 8'h5A);
    spi_deselect();
    check("underrun_flag", tx_underrun, 1'b1);
    host_read(); host_read();
    host_clear();

    // Partial byte discarded on deselect.
    spi_select();
    spi_byte(8'hFF, 1'b0, 5, -1, 8'h00, mb);
    spi_deselect();
    check("oe_deselected", spi_miso_oe, 1'b0);
    spi_select();
    spi_byte(8'h80, 1'b0, 8, -1, 8'h00, mb);
    spi_deselect();
    check("partial_80", rx_data, 8'h80);
    host_read();
    host_clear();

`ifdef SPI_TARGET_RX_FIFO_EN
    spi_select();
    for (int i = 1; i <= 5; i++) spi_byte(8'(i), 1'b0, 8, -1, 8'h00, mb);
    spi_deselect();
    check("fifo_overrun", rx_overrun, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      check("fifo_valid", rx_valid, 1'b1);
      check("fifo_pop", rx_data, 32'(i));
      host_read();
    end
    check("fifo_empty", rx_valid, 1'b0);
    host_clear();
`endif

    // Randomized traffic against the model.
    for (int k = 0; k < 150; k++) begin
      case ($urandom_range(0, 9))
        0, 1: host_load(8'($urandom_range(0, 255)));
        2, 3: host_read();
        4:    host_clear();
        5, 6, 7, 8: begin
          nb = int'($urandom_range(1, 3));
          spi_select();
          for (int b = 0; b < nb; b++) begin
            la = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1;
            spi_byte(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 8, la,
                     8'($urandom_range(0, 255)), mb);
          end
          spi_deselect();
        end
        default: begin
          spi_select();
          spi_byte(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(1, 7)), -1, 8'h00, mb);
          spi_deselect();
        end
      endcase
      cyc(int'($urandom_range(0, 3)));
    end

    cyc(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
